// File: rtl/psum_deskew_collector.sv
// Re-aligns the column-skewed bottom-edge partial sums of the PE array into row vectors
// and buffers them in a small drop-on-full FIFO with a valid/ready output.
module psum_deskew_collector #(
  parameter int ACCUM_WIDTH = 32,
  parameter int COLS        = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic [COLS*ACCUM_WIDTH-1:0]          in_psum,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [COLS*ACCUM_WIDTH-1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 overflow_err
);

  localparam int VW = COLS * ACCUM_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [COLS-2:0]          valid_sr_reg;
  logic                     aligned_valid;
  logic [ACCUM_WIDTH-1:0]   aligned_col [COLS];
  logic [VW-1:0]            aligned_vec;

  logic [VW-1:0]            mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_reg;
  logic [PW-1:0]            rd_ptr_reg;
  logic [CW-1:0]            count_reg;
  logic [CW-1:0]            count_next;
  logic                     err_reg;

  logic                     full;
  logic                     do_pop;
  logic                     do_write;
  logic                     drop;

  // Row-valid travels alongside column 0 so it lines up with the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr_reg <= '0;
    end else if (clear) begin
      valid_sr_reg <= '0;
    end else begin
      valid_sr_reg[0] <= in_valid;
      for (int k = 1; k < COLS - 1; k++) begin
        valid_sr_reg[k] <= valid_sr_reg[k-1];
      end
    end
  end

  assign aligned_valid = valid_sr_reg[COLS-2];

  // Column gi is delayed COLS-1-gi cycles; the last column needs no delay.
  genvar gi;
  generate
    for (gi = 0; gi < COLS - 1; gi++) begin : g_delay
      localparam int STAGES = COLS - 1 - gi;
      logic [ACCUM_WIDTH-1:0] stage_reg [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < STAGES; k++) begin
            stage_reg[k] <= '0;
          end
        end else begin
          stage_reg[0] <= in_psum[gi*ACCUM_WIDTH +: ACCUM_WIDTH];
          for (int k = 1; k < STAGES; k++) begin
            stage_reg[k] <= stage_reg[k-1];
          end
        end
      end

      assign aligned_col[gi] = stage_reg[STAGES-1];
    end
  endgenerate

  assign aligned_col[COLS-1] = in_psum[(COLS-1)*ACCUM_WIDTH +: ACCUM_WIDTH];

  always_comb begin
    aligned_vec = '0;
    for (int j = 0; j < COLS; j++) begin
      aligned_vec[j*ACCUM_WIDTH +: ACCUM_WIDTH] = aligned_col[j];
    end
  end

  // FIFO control; clear overrides any push or pop in the same cycle.
  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign do_pop   = out_valid && out_ready && !clear;
  assign do_write = aligned_valid && !clear && (!full || do_pop);
  assign drop     = aligned_valid && !clear && full && !do_pop;

  always_comb begin
    count_next = count_reg;
    if (do_write && !do_pop) begin
      count_next = count_reg + CW'(1);
    end else if (do_pop && !do_write) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
      if (drop) begin
        err_reg <= 1'b1;
      end
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head being
  // consumed this cycle is the slot that gets overwritten.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= aligned_vec;
    end
  end

  assign out_valid    = (count_reg != '0);
  assign out_data     = out_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_count   = count_reg;
  assign overflow_err = err_reg;

endmodule

// File: doc/psum_deskew_collector.md
# psum_deskew_collector

Output-side collector for the reconfigurable systolic PE array. It receives the PartialSum' streams that leave the bottom PE of each column. In WS/IS dataflow these streams arrive skewed by one cycle per column. The block re-aligns them into complete row vectors, buffers the vectors in a small FIFO, and hands them downstream over a valid/ready handshake. The array cannot stall, so a full FIFO results in dropped vectors and a sticky error flag, never in backpressure.

## Interface
Parameters:
- ACCUM_WIDTH, 32, width of one partial sum; matches the PE accumulator width
- COLS, 4, number of array columns (≥2)
- FIFO_DEPTH, 4, number of aligned vectors buffered (power of two, ≥2)

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush: empties the FIFO and the in-flight valids, and clears overflow_err
- in_valid  in  1  high in the cycle that column 0's psum for a row is presented
- in_psum  in  COLS*ACCUM_WIDTH  bottom-edge psums; column j occupies bits [j*ACCUM_WIDTH +: ACCUM_WIDTH]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts the head vector
- out_data  out  COLS*ACCUM_WIDTH  head vector, with the same column packing as in_psum
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of vectors buffered
- overflow_err  out  1  sticky; set when an aligned vector is dropped

## Operation
- Skew contract: if in_valid is high in cycle t, column j's psum for that row is valid on in_psum in cycle t+j. The block does not sample in_valid for columns ≥1.
- Deskew: column j passes through (COLS-1-j) register stages, so column COLS-1 is combinational. in_valid passes through a COLS-1 stage valid shift register. In cycle t+COLS-1 all delay-line outputs plus aligned_valid line up.
- Push: aligned_valid=1 writes the aligned vector into the FIFO tail at the end of that cycle.
- Pop: out_valid && out_ready in a cycle advances the head at the end of that cycle.
- Full: if a push and no pop occur with fifo_count==FIFO_DEPTH, the vector is dropped, FIFO contents are unchanged, and overflow_err is set.
- Full with push and pop in the same cycle: both are performed, there is no drop, and the count stays at FIFO_DEPTH.
- Empty FIFO with push: out_valid rises in the following cycle. There is no same-cycle bypass.
- Back-to-back rows: in_valid may be high in every cycle, giving one aligned vector per cycle.
- Arithmetic: pure data movement. Values are not modified, truncated or sign-extended.
- Pointers: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is tracked separately, covering the range 0..FIFO_DEPTH.
- clear:
  - Zeroes the valid shift register, the pointers, fifo_count and overflow_err.
  - Has priority over a push or pop in the same cycle.
  - Delay-line data registers may hold stale values; valid bits alone gate them.
- Mid-operation reset: all rows in flight are discarded, with no partial vector emitted.

## Timing
- Reset values: out_valid=0, out_data=0, fifo_count=0, overflow_err=0; all delay registers, valid bits and pointers are 0.
- out_data equals the FIFO head when out_valid=1. It is 0 when the FIFO is empty.
- Latency: in_valid in cycle t leads to out_valid=1 in cycle t+COLS when the FIFO was empty. For COLS=4, that is cycle t+4.
- Throughput: 1 vector per cycle sustained while out_ready=1.
- out_valid is a registered function of the count only. It has no combinational path from in_valid or out_ready.
- overflow_err is set at the end of the dropping cycle and remains high until clear or reset.

## Test plan
- Single row, COLS=4: in_valid at cycle 0, col j value 0x10+j at cycle j, out_ready=1. Required: out_valid only in cycle 4, out_data = {0x13,0x12,0x11,0x10}, fifo_count back to 0 in cycle 5.
- Streaming: 8 consecutive rows, row r col j = r*16+j, out_ready=1. Required: 8 consecutive out_valid cycles from cycle 4, vectors in order, fifo_count ≤1, overflow_err=0.
- Fill and overflow: out_ready=0, 5 rows. Required: fifo_count=4, the 5th row dropped, overflow_err=1. Draining then yields rows 0–3 only.
- Full with simultaneous push and pop: FIFO full, out_ready=1 in the cycle a 5th aligned vector arrives. Required: no drop, overflow_err=0, count stays 4, all 5 rows are eventually read in order.
- clear: 2 rows buffered and 1 in flight, clear pulsed for 1 cycle. Required: fifo_count=0, out_valid=0 next cycle, overflow_err=0, and the in-flight row is never emitted.
- Async reset mid-stream: rst_n low for 1 cycle during streaming. Required: all outputs at reset values immediately, and a new row after release has latency 4.
